// File: rtl/johnson_counter_pkg.sv
// Shared sizing helpers for the Johnson counter slice.
// Used by the interface, decoder and top so all phase buses agree on width.
package johnson_counter_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;

  function automatic int phase_w(input int width);
    return $clog2(2 * width);
  endfunction

endpackage

// File: rtl/johnson_counter_if.sv
// Output bundle of the Johnson counter: code, decoded phase, wrap and illegal flags.
interface johnson_counter_if #(
  parameter int WIDTH_REG = 8
);
  import johnson_counter_pkg::*;

  localparam int PHASE_W = phase_w(WIDTH_REG);

  logic [WIDTH_REG-1:0] out;
  logic [PHASE_W-1:0]   phase;
  logic                 wrap;
  logic                 illegal;

  modport master (
    output out,
    output phase,
    output wrap,
    output illegal
  );

  modport slave (
    input out,
    input phase,
    input wrap,
    input illegal
  );

endinterface

// File: rtl/johnson_counter_decode.sv
// Combinational decode of a Johnson code into phase index, wrap and illegal flags.
module johnson_decode
  import johnson_counter_pkg::*;
#(
  parameter int WIDTH_REG = 8
) (
  input  logic [WIDTH_REG-1:0]               code,
  output logic [phase_w(WIDTH_REG)-1:0]      phase,
  output logic                               wrap,
  output logic                               illegal
);

  localparam int PHASE_W = phase_w(WIDTH_REG);
  localparam logic [WIDTH_REG-1:0] TERM_CODE = {1'b1, {(WIDTH_REG-1){1'b0}}};

  logic [PHASE_W-1:0] ones;
  logic [PHASE_W-1:0] edges;

  always_comb begin
    ones  = '0;
    edges = '0;
    for (int i = 0; i < WIDTH_REG; i++) begin
      ones = ones + PHASE_W'(code[i]);
    end
    // A legal code has at most one boundary between its run of 1s and run of 0s
    for (int i = 0; i < WIDTH_REG - 1; i++) begin
      edges = edges + PHASE_W'(code[i+1] ^ code[i]);
    end
  end

  always_comb begin
    illegal = (edges > PHASE_W'(1));
    phase   = '0;
    if (!illegal) begin
      if (code[0]) begin
        phase = ones;
      end else if (code[WIDTH_REG-1]) begin
        // Modular subtraction keeps this exact even when 2*WIDTH_REG is a power of two
        phase = PHASE_W'(2 * WIDTH_REG) - ones;
      end
    end
    wrap = !illegal && (code == TERM_CODE);
  end

endmodule

// File: rtl/johnson_counter.sv
// Johnson (twisted-ring) counter with phase decode and one-clock illegal-state recovery.
module johnson_counter
  import johnson_counter_pkg::*;
#(
  parameter int WIDTH_REG = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  johnson_counter_if.master cnt
);

  localparam int PHASE_W = phase_w(WIDTH_REG);

  if (WIDTH_REG < WIDTH_MIN || WIDTH_REG > WIDTH_MAX) begin : g_width_chk
    $error("johnson_counter: WIDTH_REG out of range 2..64");
  end

  logic [WIDTH_REG-1:0] cnt_q;
  logic [WIDTH_REG-1:0] cnt_d;
  logic [PHASE_W-1:0]   phase;
  logic                 wrap;
  logic                 illegal;

  johnson_decode #(
    .WIDTH_REG (WIDTH_REG)
  ) u_decode (
    .code    (cnt_q),
    .phase   (phase),
    .wrap    (wrap),
    .illegal (illegal)
  );

  // An upset code is cleared rather than shifted, so the ring is legal again next cycle
  always_comb begin
    cnt_d = {cnt_q[WIDTH_REG-2:0], ~cnt_q[WIDTH_REG-1]};
    if (illegal) begin
      cnt_d = '0;
    end
  end

  // n_rst is active-high despite its name
  always_ff @(posedge clk) begin
    if (n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt.out     = cnt_q;
  assign cnt.phase   = phase;
  assign cnt.wrap    = wrap;
  assign cnt.illegal = illegal;

endmodule

// File: tb/tb_johnson_counter.sv
// Scoreboard bench for johnson_counter at WIDTH_REG=4 and WIDTH_REG=32.
module tb_johnson_counter;

  typedef struct {
    logic [63:0] code;
    int          phase;
    bit          wrap;
    bit          illegal;
  } exp_t;

  logic clk;
  logic n_rst4;
  logic n_rst32;

  johnson_counter_if #(.WIDTH_REG(4))  if4 ();
  johnson_counter_if #(.WIDTH_REG(32)) if32 ();

  johnson_counter #(.WIDTH_REG(4)) dut4 (
    .clk   (clk),
    .n_rst (n_rst4),
    .cnt   (if4)
  );

  johnson_counter #(.WIDTH_REG(32)) dut32 (
    .clk   (clk),
    .n_rst (n_rst32),
    .cnt   (if32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t q4[$];
  exp_t q32[$];
  int   idx4     = 0;
  int   idx32    = 0;
  bit   bad4     = 1'b0;
  bit   rst32_seen = 1'b0;
  int   wraps32  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Johnson code for index k of a w-bit ring: k low ones, then high ones shrinking
  function automatic logic [63:0] jcode(input int w, input int k);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    if (k <= w) return (64'd1 << k) - 64'd1;
    return mask & ~((64'd1 << (k - w)) - 64'd1);
  endfunction

  task automatic step(input bit r4, input bit r32);
    exp_t        e;
    logic [31:0] prev32;
    n_rst4  = r4;
    n_rst32 = r32;
    idx4  = (r4 || bad4) ? 0 : (idx4 + 1) % 8;
    bad4  = 1'b0;
    idx32 = r32 ? 0 : (idx32 + 1) % 64;
    q4.push_back('{jcode(4, idx4), idx4, idx4 == 7, 1'b0});
    q32.push_back('{jcode(32, idx32), idx32, idx32 == 63, 1'b0});
    prev32 = if32.out;
    @(posedge clk);
    #1;
    e = q4.pop_front();
    check("out4",     64'(if4.out),     e.code);
    check("phase4",   64'(if4.phase),   64'(e.phase));
    check("wrap4",    64'(if4.wrap),    64'(e.wrap));
    check("illegal4", 64'(if4.illegal), 64'(e.illegal));
    e = q32.pop_front();
    check("out32",     64'(if32.out),     e.code);
    check("phase32",   64'(if32.phase),   64'(e.phase));
    check("wrap32",    64'(if32.wrap),    64'(e.wrap));
    check("illegal32", 64'(if32.illegal), 64'(e.illegal));
    if (!r32 && rst32_seen) begin
      check("onebit32", 64'($countones(if32.out ^ prev32)), 64'd1);
    end
    if (r32) rst32_seen = 1'b1;
    if (if32.wrap) wraps32++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    n_rst4  = 1'b1;
    n_rst32 = 1'b1;
    @(negedge clk);

    // Reset both counters together
    step(1'b1, 1'b1);

    // 64 counting clocks: eight periods of the 4-bit ring, one of the 32-bit ring
    wraps32 = 0;
    for (int i = 0; i < 64; i++) step(1'b0, 1'b0);
    check("wraps32_per_period", 64'(wraps32), 64'd1);
    check("out32_home", 64'(if32.out), 64'd0);

    // Reset mid-count at 1110
    for (int i = 0; i < 8 && idx4 != 5; i++) step(1'b0, 1'b0);
    check("at_1110", 64'(if4.out), 64'hE);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // Illegal code self-corrects to zero on the next edge
    force dut4.cnt_q = 4'b0101;
    #1;
    check("illegal_flag", 64'(if4.illegal), 64'd1);
    check("illegal_phase", 64'(if4.phase), 64'd0);
    check("illegal_wrap", 64'(if4.wrap), 64'd0);
    release dut4.cnt_q;
    bad4 = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Reset wins over correction, with no extra step afterwards
    force dut4.cnt_q = 4'b0110;
    #1;
    check("illegal_flag2", 64'(if4.illegal), 64'd1);
    release dut4.cnt_q;
    bad4 = 1'b1;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
